soma_scheduler: RTL and testbench
=================================

// Module: soma_scheduler
// PURPOSE
//  Per-timestep sequencer for the soma datapath.
//  - On a start pulse: walks neuron addresses 0..neuron_num-1 and drives config_soma_vld/_vm_addr/_clear, one neuron per cycle.
//  - Update mode: samples soma_spk_out_fire one cycle after each issue and queues each firing index to the spike-out side (valid/ready).
//  - Sits between the node controller (start/done) and the soma/spike-out path.
// PARAMETERS
//  NNW        12  neuron index width; also width of config_soma_vm_addr and spk_addr
//  FIFO_DEPTH  4  spike index FIFO entries (power of 2, >=2)
//  FAW         2  log2(FIFO_DEPTH)
// PORTS
//  clk_soma             in   1    single clock, all logic rising-edge
//  rst                  in   1    synchronous, active-high reset
//  start                in   1    1-cycle pulse: begin one scan; ignored while busy
//  clear_mode           in   1    sampled with start: 1 = clear scan (Vm<=0), 0 = update scan
//  neuron_num           in   NNW  neurons to scan, sampled with start; 0 = empty scan
//  config_soma_vld      out  1    soma update/clear request for config_soma_vm_addr
//  config_soma_vm_addr  out  NNW  neuron being issued
//  config_soma_clear    out  1    = latched clear_mode while config_soma_vld=1, else 0
//  soma_spk_out_fire    in   1    soma compare result, valid the cycle after an issue
//  axon_soma_we         in   1    monitored only, for conflict detection
//  spk_vld              out  1    FIFO head valid
//  spk_addr             out  NNW  FIFO head neuron index
//  spk_rdy              in   1    spike-out accepts head when spk_vld&spk_rdy
//  busy                 out  1    1 from cycle after accepted start until done
//  done                 out  1    1-cycle pulse at end of scan
//  err_axon_conflict    out  1    sticky: axon_soma_we seen while busy; cleared by rst or accepted start
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; addr counter 0; FIFO empty; pending flag 0. Reset mid-scan aborts, no done pulse.
//  - FSM states:
//    IDLE: start -> latch mode and N, cnt<=0, err<=0; N==0 -> DRAIN, else -> SCAN.
//    SCAN: issue cnt when FIFO has space; after issuing cnt==N-1 -> DRAIN.
//    DRAIN: wait pending==0 && FIFO empty -> assert done, -> IDLE.
//  - Issue cycle t: config_soma_vld=1, vm_addr=cnt, cnt++.
//    At end of t+1: pending sample {addr}. Update mode and fire=1 -> push addr into FIFO.
//    Clear mode: fire is never sampled, since soma reads no Vm then and fire is meaningless.
//  - Back-pressure: in update mode, issue only if fifo_count + pending < FIFO_DEPTH, so a fire never finds the FIFO full.
//    Clear mode issues every cycle. Gaps leave config_soma_vld=0 and addr held.
//  - Back-to-back issue is allowed: soma writes back at t+1 while reading the next neuron at t+1.
//  - FIFO: spk_vld = !empty. Push and pop in the same cycle are both honoured; count unchanged. Pointers wrap mod FIFO_DEPTH.
//  - Axon writes to Vm during a scan are a system-level violation: set err_axon_conflict, scan continues unchanged.
//  - done is asserted in the same cycle busy falls. A start in that cycle is ignored; start is accepted only in IDLE.
//  - cnt is NNW+1 bits internally, so N=2^NNW-1 terminates without wrap.
// STRUCTURE
//  - Shared node package: NNW default; FSM state encoding localparams (IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2).
//  - One sub-module: spk_idx_fifo (sync FIFO, width NNW, depth FIFO_DEPTH, push/pop/count/empty/full).
//  - FSM, counter and sample pipeline stay in soma_scheduler.
// TESTING
//  1 N=4, update, spk_rdy=1, fire at addr 1,3 -> vld on 4 consecutive cycles with addr 0,1,2,3; spk_addr 1 then 3; one done; busy high throughout.
//  2 N=8, update, all fire, spk_rdy=0 for 20 cycles -> exactly 4 issues then vld stalls; after rdy=1: indices 0..7 in order, none lost/duplicated.
//  3 N=3, clear_mode=1, fire forced 1 -> clear=1 on all 3 issues, spk_vld never 1, done 1 cycle after last issue+1.
//  4 N=0 -> no vld, done pulse, busy 1 cycle; second start pulsed mid-scan (N=4) ignored, exactly one done.
//  5 axon_soma_we=1 for 1 cycle during scan -> err_axon_conflict sticks, scan completes; next start clears it.
//  6 rst asserted at 2nd issue of N=6 scan -> next cycle all outputs 0, FIFO empty, no done; fresh start works.

Source files
------------

// File: rtl/soma_scheduler_pkg.sv
// Shared definitions for the soma scheduler: widths, FIFO sizing and FSM encoding.
package soma_scheduler_pkg;

    // Neuron index width (also width of config_soma_vm_addr and spk_addr)
    localparam int NNW        = 12;
    // Spike index FIFO sizing (FIFO_DEPTH must be a power of 2, >= 2)
    localparam int FIFO_DEPTH = 4;
    localparam int FAW        = 2;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        DRAIN = ST_DRAIN
    } state_e;

    // True when one more outstanding index still fits in the FIFO:
    // queued entries plus the in-flight sample must stay below the depth.
    function automatic logic fifo_has_room(input int fifo_count, input logic pend, input int depth);
        return (fifo_count + int'(pend)) < depth;
    endfunction

endpackage

// File: rtl/soma_scheduler_if.sv
// Bus bundle between the node controller / soma / spike-out environment and the scheduler.
// Handshake: a spike index moves on every rising edge where spk_vld && spk_rdy;
// spk_vld never depends on spk_rdy, and spk_addr is stable while spk_vld is high and not accepted.
interface soma_scheduler_if #(
    parameter int NNW = soma_scheduler_pkg::NNW
);
    // Controller side
    logic           start;
    logic           clear_mode;
    logic [NNW-1:0] neuron_num;
    logic           busy;
    logic           done;
    logic           err_axon_conflict;
    // Soma side
    logic           config_soma_vld;
    logic [NNW-1:0] config_soma_vm_addr;
    logic           config_soma_clear;
    logic           soma_spk_out_fire;
    logic           axon_soma_we;
    // Spike-out side
    logic           spk_vld;
    logic [NNW-1:0] spk_addr;
    logic           spk_rdy;

    // Environment driving the scheduler
    modport master (
        output start, clear_mode, neuron_num, soma_spk_out_fire, axon_soma_we, spk_rdy,
        input  busy, done, err_axon_conflict, config_soma_vld, config_soma_vm_addr,
               config_soma_clear, spk_vld, spk_addr
    );

    // The scheduler itself
    modport slave (
        input  start, clear_mode, neuron_num, soma_spk_out_fire, axon_soma_we, spk_rdy,
        output busy, done, err_axon_conflict, config_soma_vld, config_soma_vm_addr,
               config_soma_clear, spk_vld, spk_addr
    );
endinterface

// File: rtl/soma_scheduler_spk_idx_fifo.sv
// Small synchronous FIFO holding firing neuron indices until spike-out accepts them.
// Simultaneous push and pop are both honoured; pointers wrap modulo DEPTH.
module soma_scheduler_spk_idx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A push into a full FIFO is only legal when the head leaves in the same cycle
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/soma_scheduler.sv
// Per-timestep soma sequencer: walks neurons 0..N-1, one per cycle, issuing
// update or clear requests to the soma, and in update mode forwards the index
// of every neuron that fired to the spike-out side through a small FIFO.
module soma_scheduler
    import soma_scheduler_pkg::*;
#(
    parameter int NNW        = soma_scheduler_pkg::NNW,
    parameter int FIFO_DEPTH = soma_scheduler_pkg::FIFO_DEPTH,
    parameter int FAW        = soma_scheduler_pkg::FAW
) (
    input  logic             clk_soma,
    input  logic             rst,
    soma_scheduler_if.slave  bus,
    output state_e           state_dbg
);

    state_e         state_q,     state_d;
    // Counter and limit are one bit wider so N = 2^NNW-1 terminates without wrap
    logic [NNW:0]   cnt_q,       cnt_d;
    logic [NNW:0]   n_q,         n_d;
    logic           mode_q,      mode_d;
    logic           pend_vld_q,  pend_vld_d;
    logic [NNW-1:0] pend_addr_q, pend_addr_d;
    logic           err_q,       err_d;

    logic           issue;
    logic           done;
    logic           room;

    logic [FAW:0]   fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fifo_push;
    logic           fifo_pop;
    logic [NNW-1:0] fifo_head;

    // Clear scans never produce spikes, so they issue every cycle; update scans
    // reserve a FIFO slot per outstanding sample so a fire never finds it full.
    assign room = mode_q || (!fifo_full && fifo_has_room(int'(fifo_count), pend_vld_q, FIFO_DEPTH));

    // The soma result belongs to the neuron issued last cycle
    assign fifo_push = pend_vld_q && !mode_q && bus.soma_spk_out_fire;
    assign fifo_pop  = !fifo_empty && bus.spk_rdy;

    // FSM next-state, issue control, sample pipeline and conflict flag
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        mode_d      = mode_q;
        pend_vld_d  = 1'b0;
        pend_addr_d = pend_addr_q;
        err_d       = err_q;
        issue       = 1'b0;
        done        = 1'b0;

        // Axon writes during a scan are flagged but do not disturb the scan
        if (state_q != IDLE && bus.axon_soma_we) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.clear_mode;
                    n_d     = {1'b0, bus.neuron_num};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.neuron_num == '0) ? DRAIN : SCAN;
                end
            end
            SCAN: begin
                if (room) begin
                    issue       = 1'b1;
                    pend_vld_d  = 1'b1;
                    pend_addr_d = cnt_q[NNW-1:0];
                    cnt_d       = cnt_q + (NNW+1)'(1);
                    if (cnt_q + (NNW+1)'(1) == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pend_vld_q && fifo_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state registers
    always_ff @(posedge clk_soma) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            err_q       <= err_d;
        end
    end

    soma_scheduler_spk_idx_fifo #(
        .W     (NNW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FAW)
    ) u_spk_idx_fifo (
        .clk       (clk_soma),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pend_addr_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.config_soma_vld     = issue;
    assign bus.config_soma_vm_addr = cnt_q[NNW-1:0];
    assign bus.config_soma_clear   = issue && mode_q;
    assign bus.spk_vld             = !fifo_empty;
    assign bus.spk_addr            = fifo_head;
    assign bus.busy                = (state_q != IDLE);
    assign bus.done                = done;
    assign bus.err_axon_conflict   = err_q;
    assign state_dbg               = state_q;

endmodule

// File: tb/tb_soma_scheduler.sv
// Directed bench for soma_scheduler with an expected-issue and expected-spike scoreboard.
module tb_soma_scheduler;
    import soma_scheduler_pkg::*;

    logic   clk_soma;
    logic   rst;
    state_e state_dbg;

    soma_scheduler_if bus ();

    soma_scheduler dut (
        .clk_soma  (clk_soma),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial begin
        clk_soma = 1'b0;
        forever #5 clk_soma = ~clk_soma;
    end

    int cyc = 0;
    always @(posedge clk_soma) cyc <= cyc + 1;

    // Scoreboard state
    logic [NNW:0]   exp_iss_q[$];   // {clear, addr}
    logic [NNW-1:0] exp_spk_q[$];
    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int first_issue = -1;
    int last_issue = -1;
    int busy_cycles = 0;
    int spk_vld_cycles = 0;
    int done_cnt = 0;
    int done_cycle = -1;

    // Soma fire model
    logic [255:0] fire_mask = '0;
    logic         fire_force = 1'b0;
    logic         fire_next = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares issues and accepted spikes against the expected queues
    always @(negedge clk_soma) begin
        logic [NNW:0]   e_iss;
        logic [NNW-1:0] e_spk;
        if (bus.config_soma_vld) begin
            issue_cnt++;
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
            if (exp_iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: actual addr=%0d clear=%0d required=no issue",
                         bus.config_soma_vm_addr, bus.config_soma_clear);
            end else begin
                e_iss = exp_iss_q.pop_front();
                check("issue_clear_addr", {bus.config_soma_clear, bus.config_soma_vm_addr}, e_iss);
            end
        end
        if (bus.spk_vld && bus.spk_rdy) begin
            if (exp_spk_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spike_unexpected: actual spk_addr=%0d required=no spike", bus.spk_addr);
            end else begin
                e_spk = exp_spk_q.pop_front();
                check("spike_addr", bus.spk_addr, e_spk);
            end
        end
        if (bus.spk_vld) spk_vld_cycles++;
        if (bus.busy) busy_cycles++;
        if (bus.done) begin
            done_cnt++;
            done_cycle = cyc;
        end
        fire_next = bus.config_soma_vld && (fire_force || fire_mask[bus.config_soma_vm_addr[7:0]]);
    end

    // Drive the soma result the cycle after each issue
    initial begin
        bus.soma_spk_out_fire = 1'b0;
        forever begin
            @(posedge clk_soma);
            #1 bus.soma_spk_out_fire = fire_next;
        end
    end

    // Driver tasks
    task automatic start_scan(input logic cm, input int n);
        for (int i = 0; i < n; i++) begin
            exp_iss_q.push_back({cm, NNW'(i)});
            if (!cm && (fire_force || fire_mask[i])) exp_spk_q.push_back(NNW'(i));
        end
        @(posedge clk_soma);
        #1;
        bus.start      = 1'b1;
        bus.clear_mode = cm;
        bus.neuron_num = NNW'(n);
        @(posedge clk_soma);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk_soma);
            k++;
        end
        check(nm, (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_soma);
        #1;
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_vld"},   bus.config_soma_vld, 0);
        check({pfx, "_addr"},  bus.config_soma_vm_addr, 0);
        check({pfx, "_clear"}, bus.config_soma_clear, 0);
        check({pfx, "_spk_vld"}, bus.spk_vld, 0);
        check({pfx, "_busy"},  bus.busy, 0);
        check({pfx, "_done"},  bus.done, 0);
        check({pfx, "_err"},   bus.err_axon_conflict, 0);
        check({pfx, "_state"}, state_dbg, IDLE);
    endtask

    int base;
    int d_base;

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.clear_mode   = 1'b0;
        bus.neuron_num   = '0;
        bus.axon_soma_we = 1'b0;
        bus.spk_rdy      = 1'b0;
        repeat (3) @(posedge clk_soma);
        #1 rst = 1'b0;
        @(negedge clk_soma);
        check_quiet("reset");

        // 1: N=4 update, fires at 1 and 3, spike-out always ready
        fire_mask = '0; fire_mask[1] = 1'b1; fire_mask[3] = 1'b1;
        bus.spk_rdy = 1'b1;
        base = issue_cnt; d_base = done_cnt; busy_cycles = 0; first_issue = -1;
        start_scan(1'b0, 4);
        wait_done(50, "t1_done_seen");
        check("t1_issue_count", issue_cnt - base, 4);
        check("t1_issue_span", last_issue - first_issue, 3);
        check("t1_busy_cycles", busy_cycles, 7);
        idle_cycles(3);
        check("t1_done_count", done_cnt - d_base, 1);

        // 2: N=8 update, all fire, spike-out stalled for 20 cycles
        fire_mask = '1;
        bus.spk_rdy = 1'b0;
        base = issue_cnt;
        start_scan(1'b0, 8);
        idle_cycles(19);
        @(negedge clk_soma);
        check("t2_stall_issues", issue_cnt - base, 4);
        check("t2_stall_spk_vld", bus.spk_vld, 1);
        check("t2_stall_head", bus.spk_addr, 0);
        check("t2_stall_busy", bus.busy, 1);
        @(posedge clk_soma);
        #1 bus.spk_rdy = 1'b1;
        wait_done(100, "t2_done_seen");
        check("t2_issue_count", issue_cnt - base, 8);
        check("t2_spikes_left", exp_spk_q.size(), 0);

        // 3: N=3 clear scan with fire forced high
        fire_mask = '0; fire_force = 1'b1;
        base = issue_cnt; spk_vld_cycles = 0; first_issue = -1;
        start_scan(1'b1, 3);
        wait_done(50, "t3_done_seen");
        check("t3_issue_count", issue_cnt - base, 3);
        check("t3_done_latency", done_cycle - last_issue, 2);
        idle_cycles(2);
        check("t3_spk_vld_cycles", spk_vld_cycles, 0);
        fire_force = 1'b0;

        // 4a: empty scan
        base = issue_cnt; d_base = done_cnt; busy_cycles = 0;
        start_scan(1'b0, 0);
        wait_done(20, "t4_empty_done_seen");
        check("t4_empty_busy", busy_cycles, 1);
        check("t4_empty_issues", issue_cnt - base, 0);

        // 4b: second start mid-scan is ignored
        fire_mask = '0;
        base = issue_cnt; d_base = done_cnt;
        start_scan(1'b0, 4);
        @(posedge clk_soma);
        #1;
        bus.start = 1'b1; bus.neuron_num = NNW'(2);
        @(posedge clk_soma);
        #1 bus.start = 1'b0;
        wait_done(50, "t4_done_seen");
        idle_cycles(10);
        check("t4_done_count", done_cnt - d_base, 1);
        check("t4_issue_count", issue_cnt - base, 4);

        // 5: axon write during scan sets a sticky error
        base = issue_cnt;
        start_scan(1'b0, 6);
        @(posedge clk_soma);
        #1 bus.axon_soma_we = 1'b1;
        @(posedge clk_soma);
        #1 bus.axon_soma_we = 1'b0;
        @(negedge clk_soma);
        check("t5_err_set", bus.err_axon_conflict, 1);
        wait_done(50, "t5_done_seen");
        check("t5_issue_count", issue_cnt - base, 6);
        @(negedge clk_soma);
        check("t5_err_sticky", bus.err_axon_conflict, 1);
        start_scan(1'b0, 1);
        @(negedge clk_soma);
        check("t5_err_cleared", bus.err_axon_conflict, 0);
        wait_done(20, "t5b_done_seen");

        // 6: reset at the second issue of an N=6 scan
        fire_mask = '1;
        bus.spk_rdy = 1'b0;
        base = issue_cnt;
        start_scan(1'b0, 6);
        for (int k = 0; k < 20 && issue_cnt < base + 1; k++) @(posedge clk_soma);
        check("t6_first_issue_seen", issue_cnt - base, 1);
        #1 rst = 1'b1;
        @(posedge clk_soma);
        #1 rst = 1'b0;
        d_base = done_cnt;
        @(negedge clk_soma);
        check_quiet("t6_after_rst");
        check("t6_issues_before_rst", issue_cnt - base, 2);
        exp_iss_q.delete();
        exp_spk_q.delete();
        bus.spk_rdy = 1'b1;
        idle_cycles(5);
        check("t6_no_done", done_cnt - d_base, 0);
        fire_mask = '0; fire_mask[1] = 1'b1;
        base = issue_cnt;
        start_scan(1'b0, 2);
        wait_done(30, "t6_fresh_done_seen");
        check("t6_fresh_issues", issue_cnt - base, 2);

        idle_cycles(3);
        check("final_issue_queue_empty", exp_iss_q.size(), 0);
        check("final_spike_queue_empty", exp_spk_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
